// File: rtl/load_store_unit_if.sv
// Word-wide memory port: initiator drives addr/wr/wdata, target returns rdata.
// No handshake on this bus; the target must accept a write and return rdata within the two-cycle access window.
interface memory_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (output addr, output wr, output wdata, input rdata);
    modport slave  (input addr, input wr, input wdata, output rdata);
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end with read-modify-write for sub-word stores; loads and sub-word stores take 3 cycles, word stores and errors 1.
// One op in flight: req_ready is low from the accept edge until the op's final cycle.
module load_store_unit #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [AW+1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            resp_valid,
    output logic [DW-1:0]   resp_rdata,
    output logic            resp_err,
    memory_if.master        mem_if
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR      = 3'd3;
    localparam logic [2:0] ERR     = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    size_q;
    logic [1:0]    lane_q;
    logic          uns_q;
    logic          we_q;
    logic          load_vld_q;
    logic [DW-1:0] rdata_q;
    logic          misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_w, input logic [DW-1:0] new_d,
                                                  input logic [1:0] sz, input logic [1:0] lane);
        logic [DW-1:0] m;
        m = old_w;
        if (sz == 2'b00) begin
            case (lane)
                2'd0:    m[7:0]   = new_d[7:0];
                2'd1:    m[15:8]  = new_d[7:0];
                2'd2:    m[23:16] = new_d[7:0];
                default: m[31:24] = new_d[7:0];
            endcase
        end else if (sz == 2'b01) begin
            if (lane[1]) m[31:16] = new_d[15:0];
            else         m[15:0]  = new_d[15:0];
        end else begin
            m = new_d;
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] extract_lanes(input logic [DW-1:0] w, input logic [1:0] sz,
                                                    input logic [1:0] lane, input logic uns);
        logic [DW-1:0] sh;
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        sh = w >> {lane, 3'b000};
        b  = sh[7:0];
        h  = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 2'b00;
            lane_q     <= 2'b00;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            load_vld_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            load_vld_q <= 1'b0;
            rdata_q    <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[AW+1:2];
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        lane_q  <= req_addr[1:0];
                        uns_q   <= req_unsigned;
                        we_q    <= req_we;
                        if (misaligned)                     state <= ERR;
                        else if (req_we && req_size == 2'b10) state <= WR;
                        else                                state <= RD_ADDR;
                    end
                end
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    // Sub-word stores fold the old word into wdata here, so WR writes a full word.
                    if (we_q) begin
                        wdata_q <= merge_lanes(mem_if.rdata, wdata_q, size_q, lane_q);
                        state   <= WR;
                    end else begin
                        load_vld_q <= 1'b1;
                        rdata_q    <= extract_lanes(mem_if.rdata, size_q, lane_q, uns_q);
                        state      <= IDLE;
                    end
                end
                WR:      state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Store/error completions are decoded from state so a reset in that cycle suppresses both write and response.
    assign req_ready    = (state == IDLE);
    assign mem_if.wr    = (state == WR) & ~rst;
    assign mem_if.addr  = addr_q;
    assign mem_if.wdata = wdata_q;
    assign resp_valid   = load_vld_q | (((state == WR) | (state == ERR)) & ~rst);
    assign resp_err     = (state == ERR) & ~rst;
    assign resp_rdata   = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW+1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;

    always #5 clk = ~clk;

    memory_if #(.AW(AW), .DW(DW)) mem_if ();

    load_store_unit #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_if       (mem_if)
    );

    // Async-read memory model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign mem_if.rdata = mem[mem_if.addr];
    always @(posedge clk) if (mem_if.wr) mem[mem_if.addr] <= mem_if.wdata;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int wr_cnt = 0;
    int resp_cnt = 0;
    int acc_cnt = 0;
    logic [AW-1:0] wr_addr_seen = '0;
    logic [DW-1:0] wr_data_seen = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) if (req_valid && req_ready && !rst) acc_cnt++;

    always @(negedge clk) begin
        exp_t e;
        if (mem_if.wr) begin
            wr_cnt++;
            wr_addr_seen = mem_if.addr;
            wr_data_seen = mem_if.wdata;
        end
        if (resp_valid) begin
            resp_cnt++;
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("resp_rdata", resp_rdata, e.data);
            end
        end
    end

    task automatic do_op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW+1:0] a, input logic [DW-1:0] d,
                         input logic exp_err, input logic [DW-1:0] exp_data, input int exp_lat);
        int lat;
        int budget;
        int wr0;
        logic wr_at;
        logic exp_wr;
        exp_wr = we && !exp_err;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
        budget = 0;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        sb_q.push_back(exp_t'{exp_err, exp_data});
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 10);
        wr_at = mem_if.wr;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_wr_at_resp"}, 32'(wr_at), 32'(exp_wr));
        @(posedge clk);
        #1;
        check({tag, "_wr_count"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int wr0;
        int rc0;
        int ac0;
        int budget;
        logic          b_we   [4];
        logic [1:0]    b_sz   [4];
        logic          b_uns  [4];
        logic [AW+1:0] b_addr [4];
        logic [DW-1:0] b_dat  [4];
        logic [DW-1:0] b_exp  [4];

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err",   32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_wr",     32'(mem_if.wr), 32'd0);
        check("rst_mem_addr",   32'(mem_if.addr), 32'd0);
        check("rst_mem_wdata",  mem_if.wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Word store then load
        do_op("sw_pre1", 1'b1, 2'b10, 1'b0, 13'h004, 32'hCAFEF00D, 1'b0, 32'h0, 1);
        do_op("sw_dead", 1'b1, 2'b10, 1'b0, 13'h010, 32'hDEADBEEF, 1'b0, 32'h0, 1);
        check("sw_dead_addr", 32'(wr_addr_seen), 32'd4);
        check("sw_dead_data", wr_data_seen, 32'hDEADBEEF);
        check("sw_dead_mem", mem[4], 32'hDEADBEEF);
        do_op("lw_dead", 1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 1'b0, 32'hDEADBEEF, 3);

        // Byte RMW
        do_op("sw_pre8", 1'b1, 2'b10, 1'b0, 13'h020, 32'h11223344, 1'b0, 32'h0, 1);
        do_op("sb_rmw",  1'b1, 2'b00, 1'b0, 13'h022, 32'h000000AA, 1'b0, 32'h0, 3);
        check("sb_rmw_addr", 32'(wr_addr_seen), 32'd8);
        check("sb_rmw_mem", mem[8], 32'h11AA3344);

        // Sign / zero extension
        do_op("sw_ext", 1'b1, 2'b10, 1'b0, 13'h000, 32'h80FF7F01, 1'b0, 32'h0, 1);
        do_op("lb_1",   1'b0, 2'b00, 1'b0, 13'h001, 32'h0, 1'b0, 32'h0000007F, 3);
        do_op("lb_2",   1'b0, 2'b00, 1'b0, 13'h002, 32'h0, 1'b0, 32'hFFFFFFFF, 3);
        do_op("lbu_2",  1'b0, 2'b00, 1'b1, 13'h002, 32'h0, 1'b0, 32'h000000FF, 3);
        do_op("lh_2",   1'b0, 2'b01, 1'b0, 13'h002, 32'h0, 1'b0, 32'hFFFF80FF, 3);
        do_op("lhu_2",  1'b0, 2'b01, 1'b1, 13'h002, 32'h0, 1'b0, 32'h000080FF, 3);
        do_op("lhu_0",  1'b0, 2'b01, 1'b1, 13'h000, 32'h0, 1'b0, 32'h00007F01, 3);

        // Misaligned and illegal size
        do_op("lw_mis",  1'b0, 2'b10, 1'b0, 13'h006, 32'h0, 1'b1, 32'h0, 1);
        do_op("sh_mis",  1'b1, 2'b01, 1'b0, 13'h003, 32'h0000BEEF, 1'b1, 32'h0, 1);
        do_op("sz3_ill", 1'b1, 2'b11, 1'b0, 13'h004, 32'h12121212, 1'b1, 32'h0, 1);
        check("mis_mem1", mem[1], 32'hCAFEF00D);
        check("mis_mem0", mem[0], 32'h80FF7F01);

        // Reset during the WR cycle of a byte RMW
        do_op("sw_pre12", 1'b1, 2'b10, 1'b0, 13'h030, 32'h55667788, 1'b0, 32'h0, 1);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 13'h030; req_wdata = 32'h00000099;
        check("rstwr_ready", 32'(req_ready), 32'd1);
        wr0 = wr_cnt;
        rc0 = resp_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstwr_wr", 32'(mem_if.wr), 32'd0);
        check("rstwr_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstwr_ready_after", 32'(req_ready), 32'd1);
        check("rstwr_wr_count", 32'(wr_cnt - wr0), 32'd0);
        check("rstwr_resp_count", 32'(resp_cnt - rc0), 32'd0);
        check("rstwr_mem", mem[12], 32'h55667788);

        // Back-to-back mixed ops with req_valid held high
        b_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
        b_sz   = '{2'b10, 2'b10, 2'b00, 2'b01};
        b_uns  = '{1'b0, 1'b0, 1'b0, 1'b1};
        b_addr = '{13'h040, 13'h040, 13'h041, 13'h040};
        b_dat  = '{32'h12345678, 32'h0, 32'h000000EE, 32'h0};
        b_exp  = '{32'h0, 32'h12345678, 32'h0, 32'h0000EE78};
        rc0 = resp_cnt;
        ac0 = acc_cnt;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_we = b_we[i]; req_size = b_sz[i]; req_unsigned = b_uns[i];
            req_addr = b_addr[i]; req_wdata = b_dat[i];
            budget = 0;
            while (!req_ready && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            check("b2b_ready", 32'(req_ready), 32'd1);
            sb_q.push_back(exp_t'{1'b0, b_exp[i]});
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        budget = 0;
        while (resp_cnt - rc0 < 4 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        @(posedge clk);
        #1;
        check("b2b_resp_count", 32'(resp_cnt - rc0), 32'd4);
        check("b2b_accept_count", 32'(acc_cnt - ac0), 32'd4);
        check("b2b_sb_empty", 32'(sb_q.size()), 32'd0);
        check("b2b_mem", mem[16], 32'h1234EE78);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
